// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG TAP master: TAP reset, IR/DR scans and idle cycles driven from a command/response interface
module jtag_scan_master #(
  parameter int IR_W   = 2,
  parameter int DR_MAX = 211,
  parameter int CNT_W  = 8
) (
  input  logic              TCLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              TMS,
  output logic              TDI,
  output logic              TRST_N,
  input  logic              TDO
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RST_SEQ  = 4'd1;
  localparam logic [3:0] S_SEL_DR   = 4'd2;
  localparam logic [3:0] S_SEL_IR   = 4'd3;
  localparam logic [3:0] S_CAPTURE  = 4'd4;
  localparam logic [3:0] S_SHIFT    = 4'd5;
  localparam logic [3:0] S_EXIT1    = 4'd6;
  localparam logic [3:0] S_UPDATE   = 4'd7;
  localparam logic [3:0] S_RUN_IDLE = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;

  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(DR_MAX);
  localparam logic [CNT_W-1:0] IR_LEN   = CNT_W'(IR_W);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(6);

  // state is the phase currently on the pins; outputs are registered from state_n
  logic [3:0]        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, len, cnt_last;
  logic [1:0]        op;
  logic [DR_MAX-1:0] data, cap;
  logic              is_cmd, accept, len_bad, err_n;
  logic              tms_n, tdi_n, trst_n_n, ready_n;

  always_comb begin
    accept   = cmd_valid && cmd_ready;
    len_bad  = (cmd_len == '0) || (cmd_len > LEN_MAX);
    cnt_last = len - ONE;
    state_n  = state;
    cnt_n    = cnt;
    err_n    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (accept) begin
          cnt_n = '0;
          case (cmd_op)
            OP_RESET: begin
              state_n = S_RST_SEQ;
              cnt_n   = ONE;
            end
            OP_IR: state_n = S_SEL_DR;
            OP_DR: begin
              state_n = len_bad ? S_DONE : S_SEL_DR;
              err_n   = len_bad;
            end
            default: state_n = (cmd_len == '0) ? S_DONE : S_RUN_IDLE;
          endcase
        end
      end
      S_RST_SEQ: begin
        if (cnt == RST_LAST) begin
          state_n = S_RUN_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_SEL_DR: begin
        state_n = (op == OP_IR) ? S_SEL_IR : S_CAPTURE;
        cnt_n   = '0;
      end
      S_SEL_IR: begin
        state_n = S_CAPTURE;
        cnt_n   = '0;
      end
      // two TMS=0 cycles: into Capture, then Capture -> Shift
      S_CAPTURE: begin
        if (cnt == '0) begin
          cnt_n = ONE;
        end else begin
          state_n = S_SHIFT;
          cnt_n   = '0;
        end
      end
      S_SHIFT: begin
        if (cnt == cnt_last) state_n = S_EXIT1;
        else cnt_n = cnt + ONE;
      end
      S_EXIT1:  state_n = S_UPDATE;
      S_UPDATE: state_n = S_DONE;
      S_RUN_IDLE: begin
        if (cnt == cnt_last) state_n = S_DONE;
        else cnt_n = cnt + ONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tms_n    = (state_n == S_RST_SEQ) || (state_n == S_SEL_DR) || (state_n == S_SEL_IR) ||
               (state_n == S_EXIT1) || ((state_n == S_SHIFT) && (cnt_n == cnt_last));
    tdi_n    = (state_n == S_SHIFT) && data[cnt_n];
    trst_n_n = !((state_n == S_RST_SEQ) && (cnt_n == ONE));
    ready_n  = (state_n == S_IDLE) || (state_n == S_DONE);
  end

  always_ff @(posedge TCLK) begin
    if (RST) begin
      state     <= S_RST_SEQ;
      cnt       <= '0;
      len       <= ONE;
      op        <= OP_RESET;
      data      <= '0;
      cap       <= '0;
      is_cmd    <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      TRST_N    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      TMS       <= tms_n;
      TDI       <= tdi_n;
      TRST_N    <= trst_n_n;
      cmd_ready <= ready_n;
      rsp_valid <= (state_n == S_DONE) && (accept || is_cmd);
      rsp_err   <= err_n;
      if (accept) begin
        op     <= cmd_op;
        is_cmd <= 1'b1;
        cap    <= '0;
        data   <= cmd_data;
        case (cmd_op)
          OP_RESET: len <= ONE;
          OP_IR: begin
            len  <= IR_LEN;
            data <= DR_MAX'(cmd_data[IR_W-1:0]);
          end
          default: len <= cmd_len;
        endcase
      end
      // the target shifts bit cnt on this same edge, so TDO still shows it
      if (state == S_SHIFT) cap[cnt] <= TDO;
      if (state == S_UPDATE) rsp_data <= cap;
    end
  end

endmodule
